// File: rtl/decode_ibuf.sv
// rtl/decode_ibuf.sv - multi-lane instruction buffer with branch/jump predecode and delay-slot tagging
//
// Circular buffer between the fetch register and a multi-issue decoder.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   flush                drop all entries and delay-slot history
//   in_valid/instr/pc/exc  up to FETCH_WIDTH fetched instructions, lane 0 oldest
//   in_ready             room for a full fetch group
//   out_valid/instr/pc/exc/is_bj/in_delay_slot  up to ISSUE_WIDTH head entries, slot 0 oldest
//   issue_take           number of head entries consumed this cycle
//   count                occupied entries
module decode_ibuf #(
  parameter int DEPTH       = 8,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DATA_W      = 32
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic [FETCH_WIDTH-1:0]             in_valid,
  input  logic [FETCH_WIDTH*DATA_W-1:0]      in_instr,
  input  logic [FETCH_WIDTH*DATA_W-1:0]      in_pc,
  input  logic [FETCH_WIDTH-1:0]             in_exc,
  output logic                               in_ready,
  output logic [ISSUE_WIDTH-1:0]             out_valid,
  output logic [ISSUE_WIDTH*DATA_W-1:0]      out_instr,
  output logic [ISSUE_WIDTH*DATA_W-1:0]      out_pc,
  output logic [ISSUE_WIDTH-1:0]             out_exc,
  output logic [ISSUE_WIDTH-1:0]             out_is_bj,
  output logic [ISSUE_WIDTH-1:0]             out_in_delay_slot,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   issue_take,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage; deliberately not reset, only pointers and count are.
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DATA_W-1:0] pc_q    [DEPTH];
  logic [DEPTH-1:0]  exc_q;
  logic [DEPTH-1:0]  bj_q;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_bj_q, last_bj_d;

  logic [CW-1:0] enq_n;
  logic          enq_go;
  logic [CW-1:0] take;
  logic [PW-1:0] idx;

  // Branch/jump classification on the MIPS-style opcode/rt/funct fields.
  function automatic logic predecode(input logic [31:0] ins);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    logic       r;
    op = ins[31:26];
    rt = ins[20:16];
    fn = ins[5:0];
    r  = 1'b0;
    case (op)
      6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111: r = 1'b1;
      6'b000001: r = (rt == 5'b00000) || (rt == 5'b00001) ||
                     (rt == 5'b10000) || (rt == 5'b10001);
      6'b000000: r = (fn == 6'b001000) || (fn == 6'b001001);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Readiness looks only at registered occupancy; a same-cycle dequeue is not credited.
  assign in_ready = (count_q <= CW'(DEPTH - FETCH_WIDTH));
  assign count    = count_q;

  always_comb begin
    enq_n = '0;
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      enq_n = enq_n + CW'(in_valid[l]);
    end
    enq_go = in_ready && (|in_valid) && !flush;
    take   = (CW'(issue_take) > count_q) ? count_q : CW'(issue_take);

    idx               = '0;
    out_valid         = '0;
    out_instr         = '0;
    out_pc            = '0;
    out_exc           = '0;
    out_is_bj         = '0;
    out_in_delay_slot = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        out_valid[i]                  = 1'b1;
        out_instr[i*DATA_W +: DATA_W] = instr_q[idx];
        out_pc[i*DATA_W +: DATA_W]    = pc_q[idx];
        out_exc[i]                    = exc_q[idx];
        out_is_bj[i]                  = bj_q[idx];
      end
    end
    // Slot 0 inherits from the last entry already issued; later slots from their predecessor.
    out_in_delay_slot[0] = out_valid[0] & last_bj_q;
    for (int i = 1; i < ISSUE_WIDTH; i++) begin
      out_in_delay_slot[i] = out_valid[i] & out_is_bj[i-1];
    end
  end

  always_comb begin
    if (flush) begin
      head_d    = tail_q;
      tail_d    = tail_q;
      count_d   = '0;
      last_bj_d = 1'b0;
    end else begin
      head_d    = head_q + PW'(take);
      tail_d    = enq_go ? tail_q + PW'(enq_n) : tail_q;
      count_d   = count_q + (enq_go ? enq_n : '0) - take;
      last_bj_d = (take != '0) ? bj_q[head_q + PW'(take - CW'(1))] : last_bj_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      last_bj_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      last_bj_q <= last_bj_d;
    end
  end

  // Lanes are packed from lane 0, so lane l lands at tail+l.
  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      if (enq_go && in_valid[l]) begin
        instr_q[tail_q + PW'(l)] <= in_instr[l*DATA_W +: DATA_W];
        pc_q[tail_q + PW'(l)]    <= in_pc[l*DATA_W +: DATA_W];
        exc_q[tail_q + PW'(l)]   <= in_exc[l];
        bj_q[tail_q + PW'(l)]    <= predecode(in_instr[l*DATA_W +: 32]);
      end
    end
  end

endmodule

// File: tb/tb_decode_ibuf.sv
// tb/tb_decode_ibuf.sv - scoreboard bench for decode_ibuf
module tb_decode_ibuf;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_instr;
  logic [63:0] in_pc;
  logic [1:0]  in_exc;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic [63:0] out_pc;
  logic [1:0]  out_exc;
  logic [1:0]  out_is_bj;
  logic [1:0]  out_in_delay_slot;
  logic [1:0]  issue_take;
  logic [3:0]  count;

  decode_ibuf #(.DEPTH(8), .FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc),
    .out_is_bj(out_is_bj), .out_in_delay_slot(out_in_delay_slot),
    .issue_take(issue_take), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
    logic        bj;
    logic        ds;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  bit   prev_bj = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc,
                      input logic exc, input logic bj);
    ent_t e;
    e.instr = instr;
    e.pc    = pc;
    e.exc   = exc;
    e.bj    = bj;
    e.ds    = prev_bj;
    sb.push_back(e);
    prev_bj = bj;
  endtask

  task automatic drv(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                     input logic [31:0] i1, input logic [31:0] p1, input logic [1:0] e,
                     input logic [1:0] tk, input logic fl);
    in_valid   = v;
    in_instr   = {i1, i0};
    in_pc      = {p1, p0};
    in_exc     = e;
    issue_take = tk;
    flush      = fl;
  endtask

  task automatic idle(input logic [1:0] tk);
    drv(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, tk, 1'b0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every entry the decoder consumes must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resetn && !flush) begin
      for (int i = 0; i < 2; i++) begin
        if (i < int'(issue_take) && out_valid[i]) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_unexpected slot%0d: got pc %0h expected no entry", i, out_pc[i*32 +: 32]);
          end else begin
            mon_e = sb.pop_front();
            chk($sformatf("slot%0d_pc", i), {32'h0, out_pc[i*32 +: 32]}, {32'h0, mon_e.pc});
            chk($sformatf("slot%0d_instr_exc_bj_ds pc=%0h", i, mon_e.pc),
                {29'h0, out_instr[i*32 +: 32], out_exc[i], out_is_bj[i], out_in_delay_slot[i]},
                {29'h0, mon_e.instr, mon_e.exc, mon_e.bj, mon_e.ds});
          end
        end
      end
    end
  end

  logic [31:0] fill_i [8] = '{32'h03E00008, 32'h00851021, 32'h0040F809, 32'h00851021,
                              32'h04100005, 32'h08000040, 32'h00851021, 32'h04020002};
  logic        fill_b [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int n;
    int guard;
    logic [31:0] wi [2];
    resetn = 1'b0;
    idle(2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", {out_pc[31:0], out_instr[31:0]}, 64'd0);
    chk("rst_bj_ds", 64'({out_is_bj, out_in_delay_slot, out_exc}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    step;

    // Two lanes: ADDIU then BEQ
    drv(2'b11, 32'h24020001, 32'hBFC00000, 32'h10400003, 32'hBFC00004, 2'b00, 2'b00, 1'b0);
    push(32'h24020001, 32'hBFC00000, 1'b0, 1'b0);
    push(32'h10400003, 32'hBFC00004, 1'b0, 1'b1);
    step;
    idle(2'b00);
    chk("t1_count", 64'(count), 64'd2);
    chk("t1_out_valid", 64'(out_valid), 64'd3);
    chk("t1_is_bj", 64'(out_is_bj), 64'd2);
    chk("t1_delay_slot", 64'(out_in_delay_slot), 64'd0);

    // Enqueue nop (with fetch exception) + ADDIU while taking one
    drv(2'b11, 32'h00000000, 32'hBFC00008, 32'h24030002, 32'hBFC0000C, 2'b01, 2'b01, 1'b0);
    push(32'h00000000, 32'hBFC00008, 1'b1, 1'b0);
    push(32'h24030002, 32'hBFC0000C, 1'b0, 1'b0);
    step;
    idle(2'b01);
    chk("t2_count", 64'(count), 64'd3);
    chk("t2_slot0_pc", 64'(out_pc[31:0]), 64'hBFC00004);
    chk("t2_delay_slot", 64'(out_in_delay_slot), 64'd2);
    step;
    idle(2'b01);
    chk("t3_slot0_pc", 64'(out_pc[31:0]), 64'hBFC00008);
    chk("t3_ds0_after_beq", 64'(out_in_delay_slot[0]), 64'd1);
    chk("t3_exc0", 64'(out_exc[0]), 64'd1);
    chk("t3_count", 64'(count), 64'd2);
    step;
    idle(2'b10);
    chk("t4_slot0_pc", 64'(out_pc[31:0]), 64'hBFC0000C);
    chk("t4_ds0", 64'(out_in_delay_slot[0]), 64'd0);
    chk("t4_count", 64'(count), 64'd1);

    // Over-take: count 1, take 2
    step;
    chk("overtake_count", 64'(count), 64'd0);
    chk("overtake_valid", 64'(out_valid), 64'd0);
    step;
    idle(2'b00);
    chk("empty_take_count", 64'(count), 64'd0);

    // Fill with predecode coverage instructions
    for (int k = 0; k < 4; k++) begin
      drv(2'b11, fill_i[2*k], 32'h100 + 32'(8*k), fill_i[2*k+1], 32'h104 + 32'(8*k),
          2'b00, 2'b00, 1'b0);
      push(fill_i[2*k], 32'h100 + 32'(8*k), 1'b0, fill_b[2*k]);
      push(fill_i[2*k+1], 32'h104 + 32'(8*k), 1'b0, fill_b[2*k+1]);
      step;
      idle(2'b00);
      chk($sformatf("fill%0d_count", k), 64'(count), 64'(2*(k+1)));
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_bj", 64'(out_is_bj), 64'd1);
    chk("full_ds", 64'(out_in_delay_slot), 64'd2);
    drv(2'b11, 32'h24000099, 32'h200, 32'h2400009A, 32'h204, 2'b00, 2'b00, 1'b0);
    step;
    idle(2'b10);
    chk("full_reject_count", 64'(count), 64'd8);
    step;
    chk("after_take_count", 64'(count), 64'd6);
    chk("after_take_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("drain%0d_count", k), 64'(count), 64'(4 - 2*k));
    end

    // Wrap: enqueue 2 / take 2 for 20 cycles; every fifth instruction is a BNE
    for (int k = 0; k < 20; k++) begin
      for (int j = 0; j < 2; j++) begin
        n = 2*k + j;
        wi[j] = (n % 5 == 4) ? (32'h14000000 | 32'(n)) : (32'h24000000 | 32'(n));
      end
      drv(2'b11, wi[0], 32'h1000 + 32'(8*k), wi[1], 32'h1004 + 32'(8*k), 2'b00, 2'b10, 1'b0);
      push(wi[0], 32'h1000 + 32'(8*k), 1'b0, ((2*k) % 5 == 4));
      push(wi[1], 32'h1004 + 32'(8*k), 1'b0, ((2*k+1) % 5 == 4));
      step;
      chk($sformatf("wrap%0d_count", k), 64'(count), 64'd2);
    end
    idle(2'b10);
    step;
    idle(2'b00);
    chk("wrap_drain_count", 64'(count), 64'd0);

    // Flush with last-dequeued entry a branch
    drv(2'b11, 32'h10400003, 32'h2000, 32'h24020001, 32'h2004, 2'b00, 2'b00, 1'b0);
    push(32'h10400003, 32'h2000, 1'b0, 1'b1);
    push(32'h24020001, 32'h2004, 1'b0, 1'b0);
    step;
    idle(2'b01);
    step;
    idle(2'b00);
    chk("preflush_ds0", 64'(out_in_delay_slot[0]), 64'd1);
    drv(2'b11, 32'h24020007, 32'h2008, 32'h24020008, 32'h200C, 2'b00, 2'b01, 1'b1);
    sb.delete();
    prev_bj = 1'b0;
    step;
    idle(2'b00);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    drv(2'b11, 32'h24020005, 32'h3000, 32'h24020006, 32'h3004, 2'b00, 2'b00, 1'b0);
    push(32'h24020005, 32'h3000, 1'b0, 1'b0);
    push(32'h24020006, 32'h3004, 1'b0, 1'b0);
    step;
    idle(2'b00);
    chk("postflush_ds", 64'(out_in_delay_slot), 64'd0);
    chk("postflush_pc0", 64'(out_pc[31:0]), 64'h3000);
    chk("postflush_count", 64'(count), 64'd2);

    // Final drain, bounded
    guard = 0;
    idle(2'b10);
    while (count != 0 && guard < 20) begin
      step;
      guard++;
    end
    idle(2'b00);
    chk("drain_in_budget", 64'(count), 64'd0);
    step;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_ibuf.md
Name: decode_ibuf

Overview:
- Parametrised instruction buffer and predecode stage between the fetch register and a multi-issue decoder.
- Accepts up to FETCH_WIDTH instructions per cycle and presents up to ISSUE_WIDTH head entries per cycle in program order.
- Tags each entry as branch/jump and each output slot as in-delay-slot.
- Supersedes the single-issue decode-register path: multi-lane enqueue/dequeue, per-lane delay-slot tracking, and flush with storage.

Parameters:
DEPTH, 8, number of entries; power of two, must be >= FETCH_WIDTH+ISSUE_WIDTH.
FETCH_WIDTH, 2, instructions accepted per cycle.
ISSUE_WIDTH, 2, instructions presented per cycle.
DATA_W, 32, instruction and PC width.

Ports:
clk  in  1  clock.
resetn  in  1  asynchronous active-low reset.
flush  in  1  discard all entries and delay-slot state.
in_valid  in  FETCH_WIDTH  per-lane valid; packed from lane 0, no gaps.
in_instr  in  FETCH_WIDTH*DATA_W  raw instructions, lane 0 oldest.
in_pc  in  FETCH_WIDTH*DATA_W  PCs.
in_exc  in  FETCH_WIDTH  fetch exception flag per lane.
in_ready  out  1  free entries >= FETCH_WIDTH.
out_valid  out  ISSUE_WIDTH  head entries present; packed from slot 0.
out_instr  out  ISSUE_WIDTH*DATA_W  head instructions, slot 0 oldest.
out_pc  out  ISSUE_WIDTH*DATA_W  head PCs.
out_exc  out  ISSUE_WIDTH  fetch exception flags.
out_is_bj  out  ISSUE_WIDTH  entry is a branch/jump.
out_in_delay_slot  out  ISSUE_WIDTH  entry follows a branch/jump in program order.
issue_take  in  $clog2(ISSUE_WIDTH+1)  number of head entries consumed this cycle.
count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async, resetn low):
  - Head/tail pointers 0, count 0, last-dequeued-bj register 0.
  - out_valid 0, in_ready 1, all other outputs 0.
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH with no extra handling.
  - count is registered.
- Enqueue:
  - Occurs when in_ready and any in_valid.
  - Writes popcount(in_valid) entries at tail, tail+1, ... and advances tail by that amount.
  - Is all-or-nothing: lanes offered while in_ready=0 are ignored and not stored.
- in_ready:
  - Is computed from registered count only: DEPTH-count >= FETCH_WIDTH.
  - Is not credited with a same-cycle dequeue.
- Predecode, computed at enqueue and stored with the entry. is_bj=1 when any of:
  - opcode 000010 or 000011.
  - opcode 000100..000111.
  - opcode 000001 with rt in {00000,00001,10000,10001}.
  - opcode 000000 with funct 001000 or 001001.
- Outputs:
  - out_valid[i] = (i < count).
  - Slot i shows entry head+i; the outputs are combinational reads of the registered storage.
  - Invalid slots drive 0.
- out_in_delay_slot:
  - Slot 0 = last-dequeued-bj register.
  - Slot i>0 = is_bj of slot i-1.
- Dequeue:
  - take = min(issue_take, count).
  - Head advances by take.
  - If take>0, last-dequeued-bj <= is_bj of slot take-1.
  - take=0 leaves last-dequeued-bj unchanged.
- Simultaneous enqueue and dequeue:
  - count_next = count + enq - take.
  - Entries enqueued this cycle are visible on outputs the next cycle; there is no bypass.
- flush:
  - Highest priority: next cycle count 0, head = tail, last-dequeued-bj 0.
  - Same-cycle enqueue and dequeue are discarded.
- Full: count=DEPTH. in_ready=0; dequeue still permitted.
- Empty: out_valid all 0; issue_take ignored.
- Storage contents are not reset; only pointers and count are.

Test Plan:
- Reset, then enqueue 2 lanes (0x24020001 at pc 0xBFC00000, 0x10400003 BEQ at 0xBFC00004). Next cycle:
  - count=2, out_valid=2'b11.
  - out_is_bj=2'b10, out_in_delay_slot=2'b00.
- Take 2 of {BEQ, nop}:
  - take 1: slot0=nop with out_in_delay_slot[0]=1.
  - take 1 again: slot0 next entry with out_in_delay_slot[0]=0.
- Fill DEPTH=8 with 4 double enqueues:
  - count=8, in_ready=0.
  - A 5th offered pair is not stored.
  - issue_take=2 -> count=6, in_ready=1 the cycle after.
- Wrap: 20 cycles of enqueue 2 and take 2, PCs incrementing by 4:
  - out_pc strictly ordered with no duplicates or gaps across pointer wrap.
  - count stays 2.
- flush with in_valid=2'b11 and issue_take=1 in the same cycle:
  - Next cycle count=0, out_valid=0.
  - The following enqueue shows out_in_delay_slot[0]=0.
- Over-take: count=1, issue_take=2 -> count=0, no underflow. Predecode coverage: JR, JALR, BLTZAL, J, and ADDU (non-bj) produce is_bj 1,1,1,1,0.
